// File: rtl/stage3_pool_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// stage3_pool_scheduler_pkg
//   Shared constants for the stage-3 2x2/stride-2 max-pool scheduler:
//   default frame geometry, channel/value widths, output FIFO depth and the
//   scheduler FSM state encodings.
// -----------------------------------------------------------------------------
package stage3_pool_scheduler_pkg;

    // Default geometry of the stage-3 pooling input frame.
    localparam int POOL_IN_W       = 12;
    localparam int POOL_IN_H       = 12;

    // Channels pooled in parallel and bits per pooled value.
    localparam int POOL_CH         = 3;
    localparam int POOL_DW         = 32;

    // Output FIFO entries toward the FC stage.
    localparam int POOL_FIFO_DEPTH = 4;

    // Scheduler FSM encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/stage3_pool_fifo.sv
// -----------------------------------------------------------------------------
// stage3_pool_fifo
//   Synchronous first-word-fall-through FIFO holding pooled vectors.
//   The head entry is visible on o_data whenever the FIFO is not empty;
//   o_data reads as zero while empty.
// Ports
//   clk, reset_n  clock, asynchronous active-low reset
//   i_push        write i_data this cycle
//   i_data        WIDTH-bit entry to write
//   i_pop         retire the head entry this cycle
//   o_data        head entry (zero when empty)
//   o_count       number of stored entries
//   o_empty       no entries stored
//   o_full        DEPTH entries stored
// -----------------------------------------------------------------------------
module stage3_pool_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked by
    // the reset pointers/count, and o_data is masked while empty, so stale
    // contents are never observable.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // The scheduler never retires from an empty FIFO.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n) !(i_pop && o_empty));

endmodule

// File: rtl/stage3_pool_scheduler.sv
// -----------------------------------------------------------------------------
// stage3_pool_scheduler
//   Sequences the stage-3 2x2/stride-2 max-pool datapath for one frame:
//   tracks row/col of the incoming ReLU pixel stream, gates line-buffer
//   writes, flags each completed pooling window, captures the pooled vector
//   one cycle later into an output FIFO and throttles upstream so that a
//   pending capture always has room.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   i_start        frame start request (honoured only in IDLE)
//   i_relu_valid   upstream pixel valid
//   o_relu_ready   upstream may transfer (pixel accepted on valid && ready)
//   o_lb_wr        line-buffer write enable
//   o_lb_clear     one-cycle line-buffer clear at frame start
//   i_pool_data    pooled vector, valid the cycle after a window completes
//   o_out_valid    FIFO head valid (first-word fall-through)
//   i_out_ready    downstream accepts the head
//   o_out_data     FIFO head
//   o_busy         scheduler not idle
//   o_frame_done   one-cycle pulse once the frame is fully drained
// -----------------------------------------------------------------------------
module stage3_pool_scheduler
    import stage3_pool_scheduler_pkg::*;
#(
    parameter int IN_W  = POOL_IN_W,
    parameter int IN_H  = POOL_IN_H,
    parameter int CH    = POOL_CH,
    parameter int DW    = POOL_DW,
    parameter int DEPTH = POOL_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_relu_valid,
    output logic              o_relu_ready,
    output logic              o_lb_wr,
    output logic              o_lb_clear,
    input  logic [CH*DW-1:0]  i_pool_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CH*DW-1:0]  o_out_data,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

    if ((IN_W % 2) != 0) begin : g_bad_in_w
        $error("stage3_pool_scheduler: IN_W must be even");
    end
    if ((IN_H % 2) != 0) begin : g_bad_in_h
        $error("stage3_pool_scheduler: IN_H must be even");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("stage3_pool_scheduler: DEPTH must be >= 2");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_pending;

    logic             w_start;
    logic             w_accept;
    logic             w_last_col;
    logic             w_last_pix;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    logic             w_full;

    assign w_start    = (r_state == ST_IDLE) && i_start;
    assign w_accept   = i_relu_valid && o_relu_ready;
    assign w_last_col = (r_col == COL_LAST);
    assign w_last_pix = w_last_col && (r_row == ROW_LAST);
    assign w_pop      = o_out_valid && i_out_ready;

    // Counting the pending capture as occupied guarantees it always fits,
    // even if downstream stalls on the very cycle it lands.
    assign o_relu_ready = (r_state == ST_RUN) &&
                          (({1'b0, w_count} + {{CNT_W{1'b0}}, r_pending}) < (CNT_W + 1)'(DEPTH));
    assign o_lb_wr      = w_accept;
    assign o_lb_clear   = w_start;
    assign o_out_valid  = !w_empty;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = (r_state == ST_DONE);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // w_state_nxt unassigned, which would infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start)                w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && w_last_pix) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty && !r_pending)  w_state_nxt = ST_DONE;
            ST_DONE:                              w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_pix ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            // Bottom-right pixel of a 2x2 window: the pooled result appears
            // on i_pool_data in the following cycle.
            r_pending <= w_accept && r_row[0] && r_col[0];
        end
    end

    stage3_pool_fifo #(
        .WIDTH (CH * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_pending),
        .i_data  (i_pool_data),
        .i_pop   (w_pop),
        .o_data  (o_out_data),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // The ready throttle must make a captured window always fit.
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n) !(r_pending && w_full));

endmodule

// File: tb/tb_stage3_pool_scheduler.sv
module tb_stage3_pool_scheduler;

    localparam int IN_W  = 4;
    localparam int IN_H  = 4;
    localparam int CH    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int PDW   = CH * DW;
    localparam int NVEC  = 22;

    logic           clk;
    logic           reset_n;
    logic           i_start;
    logic           i_relu_valid;
    logic           o_relu_ready;
    logic           o_lb_wr;
    logic           o_lb_clear;
    logic [PDW-1:0] i_pool_data;
    logic           o_out_valid;
    logic           i_out_ready;
    logic [PDW-1:0] o_out_data;
    logic           o_busy;
    logic           o_frame_done;

    stage3_pool_scheduler #(
        .IN_W  (IN_W),
        .IN_H  (IN_H),
        .CH    (CH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .i_relu_valid (i_relu_valid),
        .o_relu_ready (o_relu_ready),
        .o_lb_wr      (o_lb_wr),
        .o_lb_clear   (o_lb_clear),
        .i_pool_data  (i_pool_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [PDW-1:0] act, input logic [PDW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Pooled vector for window index i (raster order); lane c = A000_0000 | i*16+c.
    function automatic logic [PDW-1:0] win(input int i);
        logic [PDW-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            v[c*DW +: DW] = 32'hA000_0000 | 32'(i * 16 + c);
        end
        return v;
    endfunction

    // Filler driven on cycles with no capture pending.
    function automatic logic [PDW-1:0] junk(input int k);
        return {CH{32'hBAD0_0000 | 32'(k)}};
    endfunction

    typedef struct {
        logic           start;
        logic           valid;
        logic           out_ready;
        logic [PDW-1:0] pd;
        logic           e_ready;
        logic           e_lb_wr;
        logic           e_lb_clear;
        logic           e_out_valid;
        logic [PDW-1:0] e_out_data;
        logic           e_busy;
        logic           e_done;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  o_relu_ready, 0);
        check({tag, "_lb_wr"},  o_lb_wr,      0);
        check({tag, "_clear"},  o_lb_clear,   0);
        check({tag, "_ovalid"}, o_out_valid,  0);
        check({tag, "_odata"},  o_out_data,   0);
        check({tag, "_busy"},   o_busy,       0);
        check({tag, "_done"},   o_frame_done, 0);
    endtask

    // Reactive frame driver: streams 16 pixels back-to-back, drives the pooled
    // vector exactly one cycle after each window-completing acceptance, and
    // checks popped heads against the expected raster order.
    //   rel_k     : cycle from which i_out_ready is held high
    //   mid_k     : cycle at which i_start is re-pulsed inside RUN (-1 none)
    //   abort_pix : assert reset while this pixel is presented (-1 none)
    //   mode      : 1 = backpressure checks, 2 = simultaneous push/pop checks
    task automatic run_frame(input string tag, input int rel_k, input int mid_k,
                             input int abort_pix, input int mode);
        int             pix       = 0;
        int             pops      = 0;
        int             done_cnt  = 0;
        int             last_pop  = -1;
        int             done_k    = -1;
        int             widx      = 0;
        int             row;
        int             col;
        logic           pend      = 1'b0;
        logic           prev_hold = 1'b0;
        logic           acc;
        logic [PDW-1:0] prev_data = '0;
        for (int k = 0; k < 300; k++) begin
            i_start      = (k == 0) || (k == mid_k);
            i_relu_valid = (k >= 1) && (pix < IN_W * IN_H);
            i_out_ready  = (k >= rel_k);
            i_pool_data  = pend ? win(widx) : junk(k);
            #1;
            if (abort_pix >= 0 && pix == abort_pix && i_relu_valid) begin
                reset_n = 1'b0;
                #1;
                check_all_zero({tag, "_async"});
                i_start      = 1'b0;
                i_relu_valid = 1'b0;
                i_out_ready  = 1'b0;
                @(posedge clk);
                #1;
                check_all_zero({tag, "_edge"});
                @(negedge clk);
                reset_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (k == 0)     check({tag, "_clear_idle"}, o_lb_clear, 1);
            if (k == mid_k) check({tag, "_clear_mid"},  o_lb_clear, 0);
            if (prev_hold) begin
                check({tag, "_hold_valid"}, o_out_valid, 1);
                check({tag, "_hold_data"},  o_out_data,  prev_data);
            end
            if (mode == 1 && k >= 9 && k <= 13) begin
                check($sformatf("%s_bp_ready_k%0d", tag, k), o_relu_ready, 0);
                check($sformatf("%s_bp_lbwr_k%0d",  tag, k), o_lb_wr,      0);
            end
            if (mode == 2 && k == 10) begin
                check({tag, "_pp_valid"}, o_out_valid,  1);
                check({tag, "_pp_data"},  o_out_data,   win(1));
                check({tag, "_pp_ready"}, o_relu_ready, 1);
            end
            acc = i_relu_valid && o_relu_ready;
            if (o_out_valid && i_out_ready) begin
                check($sformatf("%s_pop%0d", tag, pops), o_out_data, win(pops));
                pops++;
                last_pop = k;
            end
            if (o_frame_done) begin
                done_cnt++;
                done_k = k;
            end
            prev_hold = o_out_valid && !i_out_ready;
            prev_data = o_out_data;
            @(posedge clk);
            #1;
            pend = 1'b0;
            if (acc) begin
                row  = pix / IN_W;
                col  = pix % IN_W;
                pend = (row % 2 == 1) && (col % 2 == 1);
                widx = (row / 2) * (IN_W / 2) + col / 2;
                pix++;
            end
            if (done_k >= 0) break;
        end
        i_start      = 1'b0;
        i_relu_valid = 1'b0;
        check({tag, "_pixels"},     pix,      IN_W * IN_H);
        check({tag, "_pops"},       pops,     (IN_W / 2) * (IN_H / 2));
        check({tag, "_done_once"},  done_cnt, 1);
        check({tag, "_done_after"}, (done_k > last_pop), 1);
        check({tag, "_idle"},       o_busy,   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 4x4 frame, downstream always ready: cycle 0 start, pixels on 1..16,
        // windows complete at pixels 5,7,13,15 (cycles 6,8,14,16), pooled data
        // driven one cycle later, head visible two cycles after acceptance.
        for (int k = 0; k < NVEC; k++) begin
            vecs[k].start       = (k == 0);
            vecs[k].valid       = (k >= 1) && (k <= 16);
            vecs[k].out_ready   = 1'b1;
            vecs[k].pd          = junk(k);
            vecs[k].e_ready     = (k >= 1) && (k <= 16);
            vecs[k].e_lb_wr     = (k >= 1) && (k <= 16);
            vecs[k].e_lb_clear  = (k == 0);
            vecs[k].e_out_valid = 1'b0;
            vecs[k].e_out_data  = '0;
            vecs[k].e_busy      = (k >= 1) && (k <= 20);
            vecs[k].e_done      = (k == 20);
        end
        vecs[7].pd  = win(0);  vecs[8].e_out_valid  = 1'b1;  vecs[8].e_out_data  = win(0);
        vecs[9].pd  = win(1);  vecs[10].e_out_valid = 1'b1;  vecs[10].e_out_data = win(1);
        vecs[15].pd = win(2);  vecs[16].e_out_valid = 1'b1;  vecs[16].e_out_data = win(2);
        vecs[17].pd = win(3);  vecs[18].e_out_valid = 1'b1;  vecs[18].e_out_data = win(3);

        reset_n      = 1'b0;
        i_start      = 1'b0;
        i_relu_valid = 1'b0;
        i_out_ready  = 1'b0;
        i_pool_data  = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < NVEC; k++) begin
            i_start      = vecs[k].start;
            i_relu_valid = vecs[k].valid;
            i_out_ready  = vecs[k].out_ready;
            i_pool_data  = vecs[k].pd;
            #1;
            check($sformatf("v%0d_ready", k),  o_relu_ready, vecs[k].e_ready);
            check($sformatf("v%0d_lb_wr", k),  o_lb_wr,      vecs[k].e_lb_wr);
            check($sformatf("v%0d_clear", k),  o_lb_clear,   vecs[k].e_lb_clear);
            check($sformatf("v%0d_ovalid", k), o_out_valid,  vecs[k].e_out_valid);
            if (vecs[k].e_out_valid)
                check($sformatf("v%0d_odata", k), o_out_data, vecs[k].e_out_data);
            check($sformatf("v%0d_busy", k),   o_busy,       vecs[k].e_busy);
            check($sformatf("v%0d_done", k),   o_frame_done, vecs[k].e_done);
            @(posedge clk);
            #1;
        end

        // Downstream stalled until cycle 14: ready drops once the 2nd window is
        // pending; a start pulse inside RUN must be ignored.
        run_frame("bp", 14, 3, -1, 1);
        // Release exactly as the 2nd window lands: push and pop at count 1.
        run_frame("pp", 9, -1, -1, 2);
        // Reset while pixel 7 is presented, then a clean full frame.
        run_frame("rst", 1000, -1, 7, 0);
        run_frame("post", 0, -1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
